status_reg_stack: RTL

STATUS_REG_STACK -- requirements
Module: status_reg_stack

---
 rtl/sr_pkg.sv | 22 ++
 rtl/sr_lifo.sv | 74 +++++++
 rtl/status_reg_stack.sv | 94 +++++++++
 3 files changed

// File: rtl/sr_pkg.sv
// Shared definitions for the status register with save stack:
// default sizes, flag bit positions and the stack operation encoding.
package sr_pkg;

  localparam int SR_WIDTH_DEF = 8;
  localparam int SR_DEPTH_DEF = 4;

  // Flag bit positions within the status register
  localparam int SR_C = 0;
  localparam int SR_Z = 1;
  localparam int SR_N = 2;
  localparam int SR_V = 3;
  localparam int SR_I = 4;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_XCHG = 2'd3
  } sr_op_e;

endpackage

// File: rtl/sr_lifo.sv
// Save stack for the status register: storage plus level pointer.
// The caller only issues legal operations (no push when full, no pop/xchg when empty).
module sr_lifo
  import sr_pkg::*;
#(
  parameter int WIDTH = SR_WIDTH_DEF,
  parameter int DEPTH = SR_DEPTH_DEF,
  localparam int LW = $clog2(DEPTH + 1),
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  sr_op_e           op,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [LW-1:0]    r_level;
  logic             r_full;
  logic             r_empty;

  logic [LW-1:0]    w_level_next;
  logic [IW-1:0]    w_top_idx;
  logic [IW-1:0]    w_wr_idx;
  logic             w_wr_en;

  // Index of the current top; wraps when empty, but top is never consumed then
  assign w_top_idx = IW'(r_level - LW'(1));
  assign w_wr_idx  = (op == OP_XCHG) ? w_top_idx : IW'(r_level);
  assign w_wr_en   = (op == OP_PUSH) || (op == OP_XCHG);
  assign top       = r_mem[w_top_idx];

  always_comb begin
    w_level_next = r_level;
    case (op)
      OP_PUSH: w_level_next = r_level + LW'(1);
      OP_POP:  w_level_next = r_level - LW'(1);
      default: w_level_next = r_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_level <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_level <= w_level_next;
      r_full  <= (w_level_next == LW'(DEPTH));
      r_empty <= (w_level_next == '0);
    end
  end

  // Storage carries no reset: entries above level are never observed
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (w_wr_en && (w_wr_idx == IW'(gi))) begin
          r_mem[gi] <= din;
        end
      end
    end
  endgenerate

  assign level = r_level;
  assign full  = r_full;
  assign empty = r_empty;

endmodule

// File: rtl/status_reg_stack.sv
// Status register with masked writes, an interrupt save/restore stack
// and sticky overflow/underflow flags.
module status_reg_stack
  import sr_pkg::*;
#(
  parameter int               WIDTH     = SR_WIDTH_DEF,
  parameter int               DEPTH     = SR_DEPTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              LW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_mask,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             push,
  input  logic             pop,
  input  logic             err_clr,
  output logic [WIDTH-1:0] sr_data,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty,
  output logic             ovf_err,
  output logic             unf_err
);

  logic [WIDTH-1:0] r_sr;
  logic             r_ovf;
  logic             r_unf;

  logic [WIDTH-1:0] w_sr_next;
  logic [WIDTH-1:0] w_top;
  logic             w_full;
  logic             w_empty;
  logic             w_ovf_evt;
  logic             w_unf_evt;
  sr_op_e           w_op;

  // Restores from the stack take priority over the write port; push+pop on
  // an empty stack degrades to a plain push.
  always_comb begin
    w_op      = OP_NONE;
    w_ovf_evt = 1'b0;
    w_unf_evt = 1'b0;
    w_sr_next = wr_en ? ((r_sr & ~wr_mask) | (wr_data & wr_mask)) : r_sr;
    if (push && pop && !w_empty) begin
      w_op      = OP_XCHG;
      w_sr_next = w_top;
    end else if (push) begin
      if (w_full) w_ovf_evt = 1'b1;
      else        w_op      = OP_PUSH;
    end else if (pop) begin
      if (w_empty) begin
        w_unf_evt = 1'b1;
      end else begin
        w_op      = OP_POP;
        w_sr_next = w_top;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr  <= RESET_VAL;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_sr  <= w_sr_next;
      r_ovf <= w_ovf_evt | (r_ovf & ~err_clr);
      r_unf <= w_unf_evt | (r_unf & ~err_clr);
    end
  end

  sr_lifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_lifo (
    .clk   (clk),
    .rst   (rst),
    .op    (w_op),
    .din   (r_sr),
    .top   (w_top),
    .level (level),
    .full  (w_full),
    .empty (w_empty)
  );

  assign sr_data = r_sr;
  assign full    = w_full;
  assign empty   = w_empty;
  assign ovf_err = r_ovf;
  assign unf_err = r_unf;

endmodule
